// File: rtl/rr_priority_arbiter_pkg.sv
// Shared definitions for the round-robin / fixed-priority arbiter.
//   MODE_FIXED / MODE_RR : values for the RR parameter of the top level
//   clog2_safe()         : index width helper that never returns 0
//   arb_state_t          : arbiter FSM state encoding
package rr_priority_arbiter_pkg;

  localparam bit MODE_FIXED = 1'b0;
  localparam bit MODE_RR    = 1'b1;

  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_arbiter_prio_pick.sv
// Combinational rotating priority picker.
//   vec    : request vector
//   start  : first index searched (wraps through N-1 back to 0)
//   onehot : one-hot winner, zero when vec is empty
//   idx    : binary winner index, zero when vec is empty
//   any    : at least one bit of vec is set
// HIGH_FIRST=1 reverses the bit order so that start=0 yields the highest
// set index (fixed-priority behaviour).
module rr_priority_arbiter_prio_pick
  import rr_priority_arbiter_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = clog2_safe(N),
  parameter bit HIGH_FIRST = 1'b0
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [N-1:0]   ord;
  logic [2*N-1:0] dbl;
  int             pos;
  int             p;
  logic           found;

  always_comb begin
    ord = '0;
    for (int k = 0; k < N; k++) begin
      ord[k] = HIGH_FIRST ? vec[N-1-k] : vec[k];
    end
    // Lower copy is masked below start, upper copy covers the wrap; the
    // lowest surviving set bit is the winner.
    dbl   = {ord, ord};
    pos   = 0;
    found = 1'b0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (dbl[j] && (j >= int'(start))) begin
        pos   = j;
        found = 1'b1;
      end
    end
    p = (pos >= N) ? (pos - N) : pos;
    if (HIGH_FIRST) begin
      p = N - 1 - p;
    end
    any    = found;
    idx    = found ? W'(p) : '0;
    onehot = found ? ({{(N-1){1'b0}}, 1'b1} << p) : '0;
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// N-way registered, handshaked request arbiter.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req[N]    : level-sensitive requests, bit k = requester k
//   ack       : consumer accepts the current grant (release this cycle)
//   gnt[N]    : registered one-hot grant, zero when idle
//   gnt_idx   : registered binary index of the grant, zero when idle
//   gnt_valid : registered, equals |gnt
// RR=1 rotates priority starting after the last released grant;
// RR=0 always favours the highest requesting index.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | no grant held; any request is granted on the next edge
// ST_GRANTED | grant held until ack or the owner drops its request
module rr_priority_arbiter
  import rr_priority_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = clog2_safe(N),
  parameter bit RR = MODE_RR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid
);

  arb_state_t   state;
  logic [W-1:0] ptr;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] pick_start;
  logic [N-1:0] pick_onehot;
  logic [W-1:0] pick_idx;
  logic         pick_any;
  logic         rel;

  assign rel = gnt_valid & (ack | ~req[gnt_idx]);

  // The released owner moves to the lowest priority; arbitration in the
  // same edge already uses the advanced pointer.
  always_comb begin
    ptr_nxt = ptr;
    if ((RR == MODE_RR) && rel) begin
      ptr_nxt = (gnt_idx == W'(N-1)) ? '0 : gnt_idx + W'(1);
    end
  end

  assign pick_start = (RR == MODE_RR) ? ptr_nxt : '0;

  rr_priority_arbiter_prio_pick #(
    .N          (N),
    .W          (W),
    .HIGH_FIRST (RR == MODE_FIXED)
  ) u_pick (
    .vec    (req),
    .start  (pick_start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state     <= ST_GRANTED;
            gnt       <= pick_onehot;
            gnt_idx   <= pick_idx;
            gnt_valid <= 1'b1;
          end
        end
        ST_GRANTED: begin
          if (rel) begin
            ptr <= ptr_nxt;
            if (pick_any) begin
              gnt       <= pick_onehot;
              gnt_idx   <= pick_idx;
              gnt_valid <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= '0;
          gnt_idx   <= '0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_priority_arbiter.sv
module tb_rr_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [3:0] req_a = '0, req_b = '0;
  logic [4:0] req_c = '0;
  logic       ack_a = 1'b0, ack_b = 1'b0, ack_c = 1'b0;

  logic [3:0] gnt_a, gnt_b;
  logic [4:0] gnt_c;
  logic [1:0] idx_a, idx_b;
  logic [2:0] idx_c;
  logic       vld_a, vld_b, vld_c;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    int         unit;
    logic [7:0] gnt;
    logic [3:0] idx;
    logic       vld;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rr_priority_arbiter #(.N(4), .RR(1'b1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .req(req_a), .ack(ack_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(vld_a)
  );

  rr_priority_arbiter #(.N(4), .RR(1'b0)) u_fx4 (
    .clk(clk), .rst_n(rst_n), .req(req_b), .ack(ack_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(vld_b)
  );

  rr_priority_arbiter #(.N(5), .RR(1'b1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .req(req_c), .ack(ack_c),
    .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(vld_c)
  );

  task automatic drive(input int unit, input logic [7:0] r, input logic a);
    case (unit)
      0: begin req_a = r[3:0]; ack_a = a; end
      1: begin req_b = r[3:0]; ack_b = a; end
      default: begin req_c = r[4:0]; ack_c = a; end
    endcase
  endtask

  task automatic expect_out(input string tag, input int unit,
                            input logic [7:0] g, input logic [3:0] i, input logic v);
    exp_t e;
    e.tag = tag; e.unit = unit; e.gnt = g; e.idx = i; e.vld = v;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t       e;
    logic [7:0] og;
    logic [3:0] oi;
    logic       ov;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.unit)
        0: begin og = {4'b0, gnt_a}; oi = {2'b0, idx_a}; ov = vld_a; end
        1: begin og = {4'b0, gnt_b}; oi = {2'b0, idx_b}; ov = vld_b; end
        default: begin og = {3'b0, gnt_c}; oi = {1'b0, idx_c}; ov = vld_c; end
      endcase
      n_assert++;
      assert (og === e.gnt) else begin
        n_fail++;
        $error("FAIL %s gnt observed=%b expected=%b", e.tag, og, e.gnt);
      end
      n_assert++;
      assert (oi === e.idx) else begin
        n_fail++;
        $error("FAIL %s gnt_idx observed=%0d expected=%0d", e.tag, oi, e.idx);
      end
      n_assert++;
      assert (ov === e.vld) else begin
        n_fail++;
        $error("FAIL %s gnt_valid observed=%b expected=%b", e.tag, ov, e.vld);
      end
    end
  endtask

  // Drive inputs, queue the expected post-edge outputs, clock once, compare.
  task automatic step(input string tag, input int unit, input logic [7:0] r, input logic a,
                      input logic [7:0] g, input logic [3:0] i, input logic v);
    drive(unit, r, a);
    expect_out(tag, unit, g, i, v);
    @(posedge clk);
    #1;
    check_sb();
  endtask

  initial begin
    // Reset held with all requests active on the RR unit
    drive(0, 8'h0F, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst_rr4", 0, 8'h00, 4'd0, 1'b0);
    expect_out("rst_fx4", 1, 8'h00, 4'd0, 1'b0);
    expect_out("rst_rr5", 2, 8'h00, 4'd0, 1'b0);
    check_sb();
    rst_n = 1'b1;
    step("rst_first", 0, 8'h0F, 1'b0, 8'h01, 4'd0, 1'b1);

    // Rotation with ack every cycle
    for (int k = 1; k <= 5; k++) begin
      step("rotate", 0, 8'h0F, 1'b1, 8'h01 << (k % 4), 4'(k % 4), 1'b1);
    end

    // Hold while owner keeps requesting, then withdraw
    for (int k = 0; k < 5; k++) begin
      step("hold", 0, 8'h06, 1'b0, 8'h02, 4'd1, 1'b1);
    end
    step("withdraw", 0, 8'h04, 1'b0, 8'h04, 4'd2, 1'b1);
    step("drop_all", 0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0);
    step("ack_idle", 0, 8'h00, 1'b1, 8'h00, 4'd0, 1'b0);
    step("ptr_is_3", 0, 8'h0F, 1'b0, 8'h08, 4'd3, 1'b1);
    step("to_idx2", 0, 8'h04, 1'b1, 8'h04, 4'd2, 1'b1);

    // Asynchronous reset between edges while idx 2 is granted
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 0, 8'h00, 4'd0, 1'b0);
    check_sb();
    #1;
    rst_n = 1'b1;
    step("post_rst", 0, 8'h0F, 1'b0, 8'h01, 4'd0, 1'b1);
    step("rr4_off", 0, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0);

    // Fixed priority
    step("fx_1011", 1, 8'h0B, 1'b0, 8'h08, 4'd3, 1'b1);
    step("fx_ack", 1, 8'h0B, 1'b1, 8'h08, 4'd3, 1'b1);
    step("fx_0011", 1, 8'h03, 1'b0, 8'h02, 4'd1, 1'b1);
    step("fx_ack2", 1, 8'h03, 1'b1, 8'h02, 4'd1, 1'b1);
    step("fx_off", 1, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0);

    // Non-power-of-two wrap
    step("n5_idx3", 2, 8'h08, 1'b0, 8'h08, 4'd3, 1'b1);
    step("n5_idx4", 2, 8'h11, 1'b1, 8'h10, 4'd4, 1'b1);
    step("n5_wrap", 2, 8'h11, 1'b1, 8'h01, 4'd0, 1'b1);
    step("n5_back4", 2, 8'h11, 1'b1, 8'h10, 4'd4, 1'b1);
    step("n5_ackdrop", 2, 8'h01, 1'b1, 8'h01, 4'd0, 1'b1);
    step("n5_off", 2, 8'h00, 1'b0, 8'h00, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_priority_arbiter.md
# rr_priority_arbiter

Parametrised N-way request arbiter that generalises the 4-input combinational priority encoder into a registered, handshaked grant unit. The unit supports a fixed-priority mode and a round-robin mode with a rotating pointer. It holds a grant until the consumer acknowledges or the requester withdraws. It sits between multiple requesters and one shared resource (bus, memory port, UART TX).

## Interface
- N, default 4: number of requesters, ≥2.
- W, default $clog2(N): index width.
- RR, default 1: 1 selects round-robin, 0 selects fixed priority (highest index wins, same as the existing encoder).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low (one clock; async active-low reset is fixed).
- req  in  N  request vector, level-sensitive, bit k = requester k.
- ack  in  1  consumer accepts the current grant; release on this cycle.
- gnt  out  N  one-hot grant, registered; all-zero when idle.
- gnt_idx  out  W  binary index of the granted requester; 0 when idle.
- gnt_valid  out  1  a grant is active; equals |gnt.

## Operation
- State is gnt/gnt_idx/gnt_valid plus the round-robin pointer ptr[W-1:0].
- Two states: IDLE (gnt_valid=0) and GRANTED (gnt_valid=1).
- release = gnt_valid & (ack | ~req[gnt_idx]).
- pick = winner of the current req under the mode:
  - RR=1: first set bit searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap).
  - RR=0: highest set index; ptr is unused and held at 0.
- IDLE: if |req, register pick and go to GRANTED. Otherwise stay.
- GRANTED without release: gnt, gnt_idx and gnt_valid hold, and req on other bits is ignored.
- GRANTED with release:
  - RR=1: ptr ← (gnt_idx+1) mod N. Wrap N-1 → 0 holds for non-power-of-two N.
  - If |req, a new grant is registered in the same edge. Arbitration uses the updated pointer: ptr_next, not old ptr.
  - If no requests remain, go to IDLE.
- A requester that still asserts req after its own release is eligible again, but at the lowest round-robin priority.
- ack while IDLE is ignored.
- ack and req drop in the same cycle count as a single release.
- Reset clears everything asynchronously: gnt=0, gnt_idx=0, gnt_valid=0, ptr=0.
  - A grant in flight is discarded.
  - The first edge after rst_n rises arbitrates normally from ptr=0.

## Timing
- Latency req → gnt_valid: 1 clock (req sampled at edge t, grant visible after edge t).
- Back-to-back: ack at edge t produces the next grant after the same edge t, with no idle bubble when requests are pending.
- Outputs are purely registered, with no combinational path from req/ack to gnt.
- pick is combinational, depth O(N). The block must meet timing at N=16.

## Structure
- Shared include arb_defs.vh holds MODE_FIXED=0, MODE_RR=1 and a clog2 fallback macro.
- Sub-module prio_pick: combinational, parameters N/W, inputs vec[N] and start[W], outputs one-hot, idx and any.
  - Implemented as a double-width masked search; start=0 with reversed order serves fixed mode.
  - It is the direct generalisation of the priority encoder and is unit-tested separately.
- Top level contains the state registers, release logic and pointer update only.

## Test plan
- Reset: hold rst_n=0 with req=1111, then expect all outputs 0. After release, 1 edge later expect gnt=0001, gnt_idx=0, gnt_valid=1.
- Rotation (N=4, RR=1): hold req=1111 with ack=1 every cycle. Expect gnt_idx sequence 0,1,2,3,0,1 with gnt_valid continuously 1.
- Hold and withdraw:
  - req=0110, no ack for 5 cycles: gnt_idx=1 stable.
  - Drop req[1]: expect gnt_idx=2 on the next edge and ptr=2.
  - Drop all: expect gnt_valid=0 one edge later.
- Fixed mode (RR=0): req=1011 gives gnt_idx=3. ack with req unchanged gives gnt_idx=3 again. req=0011 gives gnt_idx=1.
- Wrap at N=5, RR=1: grant index 4 via req=10001, ptr=4. ack gives ptr=0 and gnt_idx=0. Next ack gives gnt_idx=4.
- Async reset mid-grant: pulse rst_n=0 between edges while gnt_idx=2. Outputs clear without a clock edge. Afterwards req=1111 grants index 0, showing ptr was cleared.
